eda_region_walker: RTL and testbench

Flood-fill controller for the regional-maxima engine. Starting from a seed pixel, it walks the 8-connected plateau of equal-valued pixels using an internal LIFO. It reads pixel values through a 1-cycle-latency read port and drives the iterated (visited) memory's address, mark and query ports. It reports whether the plateau is a regional maximum and how many pixels it contains.

---
 rtl/eda_region_walker.sv | 241 ++++++++++++++++++++++++
 tb/tb_eda_region_walker.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eda_region_walker.sv
// eda_region_walker: LIFO flood fill over the 8-connected equal-valued plateau around a seed pixel.
// Optional macro EDA_WALKER_EARLY_EXIT_EN ends the walk at the first greater neighbour.
module eda_region_walker #(
  parameter int M          = 16,
  parameter int N          = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = $clog2(M*N)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] seed_addr,
  output logic                  pix_rd_en,
  output logic [ADDR_WIDTH-1:0] pix_rd_addr,
  input  logic [DATA_WIDTH-1:0] pix_rd_data,
  output logic                  clear,
  output logic                  new_pixel,
  output logic [ADDR_WIDTH-1:0] center_addr,
  output logic [ADDR_WIDTH-1:0] upleft_addr,
  output logic [ADDR_WIDTH-1:0] up_addr,
  output logic [ADDR_WIDTH-1:0] upright_addr,
  output logic [ADDR_WIDTH-1:0] left_addr,
  output logic [ADDR_WIDTH-1:0] right_addr,
  output logic [ADDR_WIDTH-1:0] downleft_addr,
  output logic [ADDR_WIDTH-1:0] down_addr,
  output logic [ADDR_WIDTH-1:0] downright_addr,
  output logic [7:0]            equal_positions,
  output logic [7:0]            push_positions,
  input  logic [7:0]            iterated_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  is_max,
  output logic [ADDR_WIDTH:0]   region_size,
  output logic [3:0]            dbg_state
);

  localparam int RW    = $clog2(M);
  localparam int CW    = $clog2(N);
  localparam int DEPTH = M * N;
  localparam logic [ADDR_WIDTH:0] ONE_W = {{ADDR_WIDTH{1'b0}}, 1'b1};

`ifdef EDA_WALKER_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_SEED_RD, S_SEED_WAIT, S_POP, S_READ, S_EVAL, S_PUSH, S_FINISH
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   seed_q, center_q;
  logic [DATA_WIDTH-1:0]   region_val_q;
  logic [DATA_WIDTH-1:0]   val_q [8];
  logic [ADDR_WIDTH-1:0]   stack_q [DEPTH];
  logic [ADDR_WIDTH:0]     sp_q, sp_m1, region_size_q;
  logic [3:0]              slot_q;
  logic [7:0]              push_mask_q;
  logic                    is_max_r_q, is_max_q;

  logic [RW-1:0]           row;
  logic [CW-1:0]           col;
  logic [RW:0]             row_m1, row_p1;
  logic [CW:0]             col_m1, col_p1;
  logic                    up_ok, dn_ok, lf_ok, rt_ok, nbr_vis;
  logic [7:0]              inb, eq_vec, gt_vec, push_now;
  logic [ADDR_WIDTH-1:0]   nbr [8];
  logic [2:0]              rd_pos, cap_pos, push_sel;

  // Extra top bit of each +/-1 result is the borrow/carry that flags an out-of-bounds row/column.
  assign row    = center_q[ADDR_WIDTH-1:CW];
  assign col    = center_q[CW-1:0];
  assign row_m1 = {1'b0, row} - {{RW{1'b0}}, 1'b1};
  assign row_p1 = {1'b0, row} + {{RW{1'b0}}, 1'b1};
  assign col_m1 = {1'b0, col} - {{CW{1'b0}}, 1'b1};
  assign col_p1 = {1'b0, col} + {{CW{1'b0}}, 1'b1};
  assign up_ok  = ~row_m1[RW];
  assign dn_ok  = ~row_p1[RW];
  assign lf_ok  = ~col_m1[CW];
  assign rt_ok  = ~col_p1[CW];
  assign inb    = {up_ok & lf_ok, up_ok, up_ok & rt_ok, lf_ok,
                   rt_ok, dn_ok & lf_ok, dn_ok, dn_ok & rt_ok};

  always_comb begin
    nbr[7] = {row_m1[RW-1:0], col_m1[CW-1:0]};
    nbr[6] = {row_m1[RW-1:0], col};
    nbr[5] = {row_m1[RW-1:0], col_p1[CW-1:0]};
    nbr[4] = {row, col_m1[CW-1:0]};
    nbr[3] = {row, col_p1[CW-1:0]};
    nbr[2] = {row_p1[RW-1:0], col_m1[CW-1:0]};
    nbr[1] = {row_p1[RW-1:0], col};
    nbr[0] = {row_p1[RW-1:0], col_p1[CW-1:0]};
  end

  always_comb begin
    eq_vec   = '0;
    gt_vec   = '0;
    push_sel = '0;
    for (int p = 0; p < 8; p++) begin
      eq_vec[p] = inb[p] && (val_q[p] == region_val_q);
      gt_vec[p] = inb[p] && (val_q[p] > region_val_q);
      if (push_mask_q[p]) push_sel = 3'(p);
    end
  end

  assign push_now = eq_vec & ~iterated_idx;
  assign rd_pos   = 3'd7 - slot_q[2:0];
  assign cap_pos  = rd_pos + 3'd1;
  assign sp_m1    = sp_q - ONE_W;
  assign nbr_vis  = (state_q == S_READ) || (state_q == S_EVAL) || (state_q == S_PUSH);

  assign center_addr    = center_q;
  assign upleft_addr    = nbr_vis ? nbr[7] : '0;
  assign up_addr        = nbr_vis ? nbr[6] : '0;
  assign upright_addr   = nbr_vis ? nbr[5] : '0;
  assign left_addr      = nbr_vis ? nbr[4] : '0;
  assign right_addr     = nbr_vis ? nbr[3] : '0;
  assign downleft_addr  = nbr_vis ? nbr[2] : '0;
  assign down_addr      = nbr_vis ? nbr[1] : '0;
  assign downright_addr = nbr_vis ? nbr[0] : '0;
  assign region_size    = region_size_q;
  assign is_max         = (state_q == S_FINISH) ? is_max_r_q : is_max_q;
  assign dbg_state      = state_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // start is accepted only in IDLE (level sampled for one cycle); done is a single-cycle pulse in FINISH.
  always_comb begin
    state_d         = state_q;
    busy            = 1'b1;
    done            = 1'b0;
    clear           = 1'b0;
    new_pixel       = 1'b0;
    pix_rd_en       = 1'b0;
    pix_rd_addr     = '0;
    equal_positions = '0;
    push_positions  = '0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        clear   = 1'b1;
        state_d = S_SEED_RD;
      end
      S_SEED_RD: begin
        pix_rd_en   = 1'b1;
        pix_rd_addr = seed_q;
        state_d     = S_SEED_WAIT;
      end
      S_SEED_WAIT: state_d = S_POP;
      S_POP:       state_d = S_READ;
      S_READ: begin
        if (slot_q == 4'd8) begin
          state_d = S_EVAL;
        end else begin
          pix_rd_en   = inb[rd_pos];
          pix_rd_addr = inb[rd_pos] ? nbr[rd_pos] : '0;
        end
      end
      S_EVAL: begin
        new_pixel       = 1'b1;
        equal_positions = eq_vec;
        push_positions  = push_now;
        if (EARLY_EXIT && (|gt_vec)) state_d = S_FINISH;
        else if (|push_now)          state_d = S_PUSH;
        else if (sp_q != '0)         state_d = S_POP;
        else                         state_d = S_FINISH;
      end
      S_PUSH: begin
        if ((push_mask_q & ~(8'd1 << push_sel)) == 8'd0) state_d = S_POP;
      end
      S_FINISH: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seed_q        <= '0;
      center_q      <= '0;
      region_val_q  <= '0;
      sp_q          <= '0;
      slot_q        <= '0;
      push_mask_q   <= '0;
      is_max_r_q    <= 1'b0;
      is_max_q      <= 1'b0;
      region_size_q <= '0;
      for (int p = 0; p < 8; p++) val_q[p] <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          seed_q        <= seed_addr;
          is_max_q      <= 1'b0;
          region_size_q <= '0;
        end
        S_CLEAR: begin
          sp_q       <= ONE_W;
          is_max_r_q <= 1'b1;
        end
        S_SEED_WAIT: region_val_q <= pix_rd_data;
        S_POP: begin
          center_q      <= stack_q[sp_m1[ADDR_WIDTH-1:0]];
          sp_q          <= sp_m1;
          region_size_q <= region_size_q + ONE_W;
          slot_q        <= '0;
        end
        S_READ: begin
          slot_q <= slot_q + 4'd1;
          if (slot_q != 4'd0) val_q[cap_pos] <= pix_rd_data;
        end
        S_EVAL: begin
          push_mask_q <= push_now;
          if (|gt_vec) is_max_r_q <= 1'b0;
          if (EARLY_EXIT && (|gt_vec)) sp_q <= '0;
        end
        S_PUSH: begin
          push_mask_q[push_sel] <= 1'b0;
          sp_q                  <= sp_q + ONE_W;
        end
        S_FINISH: is_max_q <= is_max_r_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR)     stack_q[0] <= seed_q;
    else if (state_q == S_PUSH) stack_q[sp_q[ADDR_WIDTH-1:0]] <= nbr[push_sel];
  end

endmodule

// File: tb/tb_eda_region_walker.sv
// Bench for eda_region_walker on a 4x4 image: vector table, hand-written corner sequences and
// random images checked against a breadth-first plateau model.
module tb_eda_region_walker;
  localparam int M = 4, N = 4, DW = 8, AW = 4, NP = M * N;

  logic          clk, reset, start;
  logic [AW-1:0] seed_addr;
  logic          pix_rd_en;
  logic [AW-1:0] pix_rd_addr;
  logic [DW-1:0] pix_rd_data;
  logic          clear, new_pixel;
  logic [AW-1:0] center_addr, upleft_addr, up_addr, upright_addr, left_addr;
  logic [AW-1:0] right_addr, downleft_addr, down_addr, downright_addr;
  logic [7:0]    equal_positions, push_positions, iterated_idx;
  logic          busy, done, is_max;
  logic [AW:0]   region_size;
  logic [3:0]    dbg_state;

  eda_region_walker #(.M(M), .N(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .seed_addr(seed_addr),
    .pix_rd_en(pix_rd_en), .pix_rd_addr(pix_rd_addr), .pix_rd_data(pix_rd_data),
    .clear(clear), .new_pixel(new_pixel), .center_addr(center_addr),
    .upleft_addr(upleft_addr), .up_addr(up_addr), .upright_addr(upright_addr),
    .left_addr(left_addr), .right_addr(right_addr), .downleft_addr(downleft_addr),
    .down_addr(down_addr), .downright_addr(downright_addr),
    .equal_positions(equal_positions), .push_positions(push_positions),
    .iterated_idx(iterated_idx), .busy(busy), .done(done), .is_max(is_max),
    .region_size(region_size), .dbg_state(dbg_state)
  );

  // ---------------- clock / environment ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] img [NP];
  bit            iter_mem [NP];
  logic [AW-1:0] nbr_a [8];
  int            di [8] = '{1, 1, 1, 0, 0, -1, -1, -1};
  int            dj [8] = '{1, 0, -1, 1, -1, 1, 0, -1};

  assign nbr_a[7] = upleft_addr;   assign nbr_a[6] = up_addr;
  assign nbr_a[5] = upright_addr;  assign nbr_a[4] = left_addr;
  assign nbr_a[3] = right_addr;    assign nbr_a[2] = downleft_addr;
  assign nbr_a[1] = down_addr;     assign nbr_a[0] = downright_addr;

  always @(posedge clk) if (pix_rd_en) pix_rd_data <= img[pix_rd_addr];

  always @(posedge clk) begin
    if (clear) begin
      for (int a = 0; a < NP; a++) iter_mem[a] <= 1'b0;
    end else begin
      if (new_pixel) iter_mem[center_addr] <= 1'b1;
      for (int p = 0; p < 8; p++) if (push_positions[p]) iter_mem[nbr_a[p]] <= 1'b1;
    end
  end

  always_comb begin
    iterated_idx = '0;
    for (int p = 0; p < 8; p++) iterated_idx[p] = iter_mem[nbr_a[p]];
  end

  // ---------------- scoreboard ----------------
  int         n_checks = 0, n_errors = 0;
  int         cnt_done, cnt_newpix, cnt_clear, cnt_push_nz, busy_after;
  int         cur_seed;
  logic [7:0] first_eq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {26'd0, pix_rd_en, clear, new_pixel, busy, done, is_max}, 32'd0);
    check({tag, "_addr_a"}, {8'd0, pix_rd_addr, center_addr, upleft_addr, up_addr,
                             upright_addr, left_addr}, 32'd0);
    check({tag, "_addr_b"}, {16'd0, right_addr, downleft_addr, down_addr, downright_addr}, 32'd0);
    check({tag, "_masks"}, {11'd0, equal_positions, push_positions, region_size}, 32'd0);
  endtask

  // Expected equal mask from image geometry: in-bounds neighbours holding the seed's value.
  function automatic logic [7:0] model_eq(input int center);
    logic [7:0] m;
    int r, c;
    m = '0;
    for (int p = 0; p < 8; p++) begin
      r = center / N + di[p];
      c = center % N + dj[p];
      if (r >= 0 && r < M && c >= 0 && c < N && img[r * N + c] == img[cur_seed]) m[p] = 1'b1;
    end
    return m;
  endfunction

  // Breadth-first reference: plateau size and whether any touching pixel is greater.
  function automatic void ref_walk(input int seed, output int size, output bit mx);
    bit vis [NP];
    int q[$];
    int a, r, c;
    for (int k = 0; k < NP; k++) vis[k] = 1'b0;
    size = 0; mx = 1'b1;
    q.push_back(seed); vis[seed] = 1'b1;
    while (q.size() > 0) begin
      a = q.pop_front();
      size++;
      for (int dr = -1; dr <= 1; dr++)
        for (int dc = -1; dc <= 1; dc++) begin
          r = a / N + dr; c = a % N + dc;
          if ((dr != 0 || dc != 0) && r >= 0 && r < M && c >= 0 && c < N) begin
            if (img[r * N + c] > img[seed]) mx = 1'b0;
            else if (img[r * N + c] == img[seed] && !vis[r * N + c]) begin
              vis[r * N + c] = 1'b1;
              q.push_back(r * N + c);
            end
          end
        end
    end
  endfunction

  task automatic sample();
    int dr, dc;
    logic [7:0] e;
    if (done)  cnt_done++;
    if (clear) cnt_clear++;
    if (push_positions != 8'd0) cnt_push_nz++;
    if (pix_rd_en && int'(pix_rd_addr) != cur_seed) begin
      dr = int'(pix_rd_addr) / N - int'(center_addr) / N;
      dc = int'(pix_rd_addr) % N - int'(center_addr) % N;
      check("rd_addr_is_neighbour",
            {31'd0, dr >= -1 && dr <= 1 && dc >= -1 && dc <= 1 && !(dr == 0 && dc == 0)}, 32'd1);
    end
    if (new_pixel) begin
      cnt_newpix++;
      e = model_eq(int'(center_addr));
      if (cnt_newpix == 1) first_eq = equal_positions;
      check("eval_equal", {24'd0, equal_positions}, {24'd0, e});
      check("eval_push", {24'd0, push_positions}, {24'd0, e & ~iterated_idx});
    end else if ((equal_positions | push_positions) != 8'd0) begin
      check("masks_outside_eval", {16'd0, equal_positions, push_positions}, 32'd0);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic load_image(input int kind);
    for (int a = 0; a < NP; a++)
      case (kind)
        0:       img[a] = 8'd5;
        1:       img[a] = (a == 10) ? 8'd9 : 8'd0;
        2:       img[a] = (a == 5 || a == 6 || a == 9) ? 8'd7 : (a == 0) ? 8'd8 : 8'd0;
        3:       img[a] = 8'd3;
        4:       img[a] = 8'd0;
        default: img[a] = 8'($urandom_range(0, 2));
      endcase
  endtask

  task automatic run_walk(input int seed, input int extra_cyc, output int done_cyc);
    int cyc;
    cnt_done = 0; cnt_newpix = 0; cnt_clear = 0; cnt_push_nz = 0; busy_after = 0;
    cur_seed = seed; first_eq = '0;
    @(negedge clk);
    start = 1'b1; seed_addr = AW'(seed);
    cyc = 0; done_cyc = -1;
    sample();
    while (done_cyc < 0 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      start     = (cyc == extra_cyc);
      seed_addr = (cyc == extra_cyc) ? AW'(0) : AW'(seed);
      sample();
      if (done) done_cyc = cyc;
    end
    if (done_cyc < 0) check("done_timeout", 32'd0, 32'd1);
    repeat (12) begin
      @(negedge clk);
      start = 1'b0;
      sample();
      if (busy) busy_after++;
    end
  endtask

  typedef struct {
    int kind; int seed; int extra_cyc; int exp_max; int exp_size; int exp_done;
  } vec_t;
  vec_t vecs [8];

  initial begin
    int dcyc, rsize;
    bit rmax;
    // done cycle counted from the start cycle: 4 setup + 12 per pixel - 1 (no push after the last).
    vecs[0] = '{0, 0, 0, 1, 16, 195};
    vecs[1] = '{1, 10, 0, 1, 1, 15};
`ifdef EDA_WALKER_EARLY_EXIT_EN
    vecs[2] = '{2, 5, 0, 0, 1, 15};
    vecs[5] = '{1, 0, 0, 0, 2, 29};
`else
    vecs[2] = '{2, 5, 0, 0, 3, 39};
    vecs[5] = '{1, 0, 0, 0, 15, 183};
`endif
    vecs[3] = '{3, 0, 0, 1, 16, 195};
    vecs[4] = '{0, 15, 0, 1, 16, 195};
    vecs[6] = '{1, 10, 6, 1, 1, 15};
    vecs[7] = '{1, 10, 15, 1, 1, 15};

    reset = 1'b1; start = 1'b0; seed_addr = '0; cur_seed = 0;
    load_image(4);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      load_image(vecs[i].kind);
      run_walk(vecs[i].seed, vecs[i].extra_cyc, dcyc);
      check("vec_is_max", {31'd0, is_max}, vecs[i].exp_max);
      check("vec_region_size", {27'd0, region_size}, vecs[i].exp_size);
      check("vec_done_cycle", dcyc, vecs[i].exp_done);
      check("vec_done_count", cnt_done, 1);
      check("vec_new_pixel_count", cnt_newpix, vecs[i].exp_size);
      check("vec_clear_count", cnt_clear, 1);
      check("vec_idle_after_done", busy_after, 0);
      if (vecs[i].exp_size == 1) check("vec_push_never", cnt_push_nz, 0);
    end

    // Seed in the top-left corner: only right, down and down-right are in bounds.
    load_image(3);
    run_walk(0, 0, dcyc);
    check("corner_first_eval", {24'd0, first_eq}, 32'h0B);

    // Reset in the middle of READ aborts silently; the next walk clears and runs in full.
    load_image(0);
    cur_seed = 0; cnt_done = 0;
    @(negedge clk); start = 1'b1; seed_addr = '0;
    @(negedge clk); start = 1'b0;
    repeat (7) begin @(negedge clk); sample(); end
    check("abort_busy_before_reset", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk); sample();
    check_reset_outputs("midreset");
    @(negedge clk); sample();
    reset = 1'b0;
    check("abort_no_done", cnt_done, 0);
    load_image(4);
    run_walk(15, 0, dcyc);
    check("after_abort_clear", cnt_clear, 1);
    check("after_abort_size", {27'd0, region_size}, 32'd16);
    check("after_abort_is_max", {31'd0, is_max}, 32'd1);
    check("after_abort_done_cycle", dcyc, 195);

    for (int t = 0; t < 30; t++) begin
      load_image(5);
      run_walk(int'($urandom_range(0, NP - 1)), 0, dcyc);
      ref_walk(cur_seed, rsize, rmax);
      check("rnd_is_max", {31'd0, is_max}, {31'd0, rmax});
      check("rnd_done_count", cnt_done, 1);
      check("rnd_new_pixel_count", cnt_newpix, {27'd0, region_size});
`ifdef EDA_WALKER_EARLY_EXIT_EN
      if (rmax) check("rnd_region_size", {27'd0, region_size}, rsize);
      else check("rnd_size_range", {31'd0, region_size >= 1 && int'(region_size) <= rsize}, 32'd1);
`else
      check("rnd_region_size", {27'd0, region_size}, rsize);
      check("rnd_done_cycle", dcyc, 12 * rsize + 3);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
